// File: rtl/morra_pkg.sv
// Shared definitions for the morra tournament controller: move and result
// codes, FSM states, tally payload and small helper functions.
package morra_pkg;

   localparam int unsigned W_MOSSA   = 2;
   localparam int unsigned W_ESITO   = 2;
   localparam int unsigned W_CONTA   = 3;
   localparam int unsigned W_MANCHE  = 5;
   localparam int unsigned W_PARTITE = 3;

   typedef enum logic [W_MOSSA-1:0] {
      NESSUNA = 2'b00,
      SASSO   = 2'b01,
      CARTA   = 2'b10,
      FORBICE = 2'b11
   } mossa_t;

   typedef enum logic [W_ESITO-1:0] {
      IN_CORSO      = 2'b00,
      VINCE_PRIMO   = 2'b01,
      VINCE_SECONDO = 2'b10,
      PAREGGIO      = 2'b11
   } esito_t;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CONFIG   = 3'd1,
      ATTESA   = 3'd2,
      GIOCA    = 3'd3,
      VERIFICA = 3'd4,
      FINE     = 3'd5
   } stato_t;

   typedef struct packed {
      logic [W_CONTA-1:0] primo;
      logic [W_CONTA-1:0] secondo;
      logic [W_CONTA-1:0] pari;
   } tally_t;

   // Saturating increment for 3-bit tallies and game counters.
   function automatic logic [W_CONTA-1:0] inc_sat(input logic [W_CONTA-1:0] v);
      return (v == '1) ? v : W_CONTA'(v + 1'b1);
   endfunction

   // Tournament winner from the final tallies.
   function automatic logic [W_ESITO-1:0] confronta(input logic [W_CONTA-1:0] a,
                                                    input logic [W_CONTA-1:0] b);
      if (a > b)      return VINCE_PRIMO;
      else if (b > a) return VINCE_SECONDO;
      else            return PAREGGIO;
   endfunction

endpackage

// File: rtl/morra_cattura.sv
// Per-player move capture: holds one accepted move per round and drives pronto.
// Ports: clk, reset, attivo (FSM in ATTESA), attivo_n (FSM next in ATTESA),
//        svuota (drop held move), mossa/valido (player input),
//        pronto (registered ready), piena (move held), tenuta (held move).
module morra_cattura
   import morra_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               attivo,
   input  logic               attivo_n,
   input  logic               svuota,
   input  logic [W_MOSSA-1:0] mossa,
   input  logic               valido,
   output logic               pronto,
   output logic               piena,
   output logic [W_MOSSA-1:0] tenuta
);

   logic               cattura_c;
   logic               piena_n;
   logic               pronto_n;
   logic [W_MOSSA-1:0] tenuta_n;

   // Capture on handshake; a 00 move is never accepted so pronto stays up.
   always_comb begin
      cattura_c = attivo && valido && pronto && (mossa != NESSUNA);
      piena_n   = piena;
      tenuta_n  = tenuta;
      if (svuota) begin
         piena_n  = 1'b0;
         tenuta_n = NESSUNA;
      end else if (cattura_c) begin
         piena_n  = 1'b1;
         tenuta_n = mossa;
      end
      pronto_n = attivo_n && !piena_n;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         piena  <= 1'b0;
         tenuta <= NESSUNA;
         pronto <= 1'b0;
      end else begin
         piena  <= piena_n;
         tenuta <= tenuta_n;
         pronto <= pronto_n;
      end
   end

endmodule

// File: rtl/morra_torneo.sv
// Morra tournament controller: sequences games and rounds, captures both
// players' moves, forwards them to the game datapath and keeps the tallies.
// Ports: clk, reset, avvia, num_partite, extra_manche, mossa_/valido_/pronto_
//        per player, primo/secondo/inizia to datapath, partita from datapath,
//        vittorie_primo/vittorie_secondo/pareggi, occupato, torneo_fine, vincitore.
// All outputs are registered and aligned with the state they belong to.
module morra_torneo
   import morra_pkg::*;
#(
   parameter int unsigned MAX_PARTITE        = 7,
   parameter int unsigned MAX_MANCHE_GUARDIA = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 avvia,
   input  logic [W_PARTITE-1:0] num_partite,
   input  logic [3:0]           extra_manche,
   input  logic [W_MOSSA-1:0]   mossa_primo,
   input  logic [W_MOSSA-1:0]   mossa_secondo,
   input  logic                 valido_primo,
   input  logic                 valido_secondo,
   output logic                 pronto_primo,
   output logic                 pronto_secondo,
   output logic [W_MOSSA-1:0]   primo,
   output logic [W_MOSSA-1:0]   secondo,
   output logic                 inizia,
   input  logic [W_ESITO-1:0]   partita,
   output logic [W_CONTA-1:0]   vittorie_primo,
   output logic [W_CONTA-1:0]   vittorie_secondo,
   output logic [W_CONTA-1:0]   pareggi,
   output logic                 occupato,
   output logic                 torneo_fine,
   output logic [W_ESITO-1:0]   vincitore
);

   stato_t                stato_q, stato_n;
   logic [W_MANCHE-1:0]   manche_q, manche_n, manche_inc;
   logic [W_PARTITE-1:0]  giocate_q, giocate_n, giocate_inc;
   logic [W_PARTITE-1:0]  num_q, num_n, num_norm;
   tally_t                tally_q, tally_n;
   logic                  svuota_c, chiusa_c;
   logic                  piena_primo, piena_secondo;
   logic [W_MOSSA-1:0]    tenuta_primo, tenuta_secondo;
   logic                  inizia_n, occupato_n, fine_n;
   logic [W_MOSSA-1:0]    primo_n, secondo_n;
   logic [W_ESITO-1:0]    vincitore_n;

   morra_cattura u_cattura_primo (
      .clk      (clk),
      .reset    (reset),
      .attivo   (stato_q == ATTESA),
      .attivo_n (stato_n == ATTESA),
      .svuota   (svuota_c),
      .mossa    (mossa_primo),
      .valido   (valido_primo),
      .pronto   (pronto_primo),
      .piena    (piena_primo),
      .tenuta   (tenuta_primo)
   );

   morra_cattura u_cattura_secondo (
      .clk      (clk),
      .reset    (reset),
      .attivo   (stato_q == ATTESA),
      .attivo_n (stato_n == ATTESA),
      .svuota   (svuota_c),
      .mossa    (mossa_secondo),
      .valido   (valido_secondo),
      .pronto   (pronto_secondo),
      .piena    (piena_secondo),
      .tenuta   (tenuta_secondo)
   );

   // Next state, counters, tallies and the next value of every output.
   always_comb begin
      stato_n     = stato_q;
      manche_n    = manche_q;
      giocate_n   = giocate_q;
      num_n       = num_q;
      tally_n     = tally_q;
      svuota_c    = 1'b0;
      chiusa_c    = 1'b0;
      manche_inc  = (manche_q == '1) ? manche_q : W_MANCHE'(manche_q + 1'b1);
      giocate_inc = inc_sat(giocate_q);
      // 0 plays one game; requests above the bound are clamped to it.
      if (num_partite == '0)
         num_norm = W_PARTITE'(1);
      else if (32'(num_partite) > MAX_PARTITE)
         num_norm = W_PARTITE'(MAX_PARTITE);
      else
         num_norm = num_partite;

      case (stato_q)
         IDLE, FINE: begin
            if (avvia) begin
               stato_n   = CONFIG;
               tally_n   = '0;
               giocate_n = '0;
               num_n     = num_norm;
            end
         end
         CONFIG: begin
            manche_n = '0;
            stato_n  = ATTESA;
         end
         ATTESA: begin
            if (piena_primo && piena_secondo) stato_n = GIOCA;
         end
         GIOCA: begin
            stato_n = VERIFICA;
         end
         VERIFICA: begin
            svuota_c = 1'b1;
            manche_n = manche_inc;
            stato_n  = ATTESA;
            case (partita)
               VINCE_PRIMO: begin
                  tally_n.primo = inc_sat(tally_q.primo);
                  chiusa_c      = 1'b1;
               end
               VINCE_SECONDO: begin
                  tally_n.secondo = inc_sat(tally_q.secondo);
                  chiusa_c        = 1'b1;
               end
               PAREGGIO: begin
                  tally_n.pari = inc_sat(tally_q.pari);
                  chiusa_c     = 1'b1;
               end
               default: begin
                  // Game still running after the guard round count: abort as a draw.
                  if (32'(manche_inc) >= MAX_MANCHE_GUARDIA) begin
                     tally_n.pari = inc_sat(tally_q.pari);
                     chiusa_c     = 1'b1;
                  end
               end
            endcase
            if (chiusa_c) begin
               giocate_n = giocate_inc;
               stato_n   = (giocate_inc < num_q) ? CONFIG : FINE;
            end
         end
         default: stato_n = IDLE;
      endcase

      inizia_n    = (stato_n == CONFIG);
      occupato_n  = !(stato_n inside {IDLE, FINE});
      fine_n      = (stato_n == FINE);
      primo_n     = NESSUNA;
      secondo_n   = NESSUNA;
      if (stato_n == CONFIG) begin
         {primo_n, secondo_n} = extra_manche;
      end else if (stato_n == GIOCA) begin
         primo_n   = tenuta_primo;
         secondo_n = tenuta_secondo;
      end
      vincitore_n = fine_n ? confronta(tally_n.primo, tally_n.secondo) : IN_CORSO;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stato_q     <= IDLE;
         manche_q    <= '0;
         giocate_q   <= '0;
         num_q       <= '0;
         tally_q     <= '0;
         inizia      <= 1'b0;
         primo       <= NESSUNA;
         secondo     <= NESSUNA;
         occupato    <= 1'b0;
         torneo_fine <= 1'b0;
         vincitore   <= IN_CORSO;
      end else begin
         stato_q     <= stato_n;
         manche_q    <= manche_n;
         giocate_q   <= giocate_n;
         num_q       <= num_n;
         tally_q     <= tally_n;
         inizia      <= inizia_n;
         primo       <= primo_n;
         secondo     <= secondo_n;
         occupato    <= occupato_n;
         torneo_fine <= fine_n;
         vincitore   <= vincitore_n;
      end
   end

   assign vittorie_primo   = tally_q.primo;
   assign vittorie_secondo = tally_q.secondo;
   assign pareggi          = tally_q.pari;

endmodule

// File: tb/tb_morra_torneo.sv
// Directed bench for morra_torneo; the bench plays the game datapath itself.
module tb_morra_torneo;
   import morra_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       avvia;
   logic [2:0] num_partite;
   logic [3:0] extra_manche;
   logic [1:0] mossa_primo, mossa_secondo;
   logic       valido_primo, valido_secondo;
   logic       pronto_primo, pronto_secondo;
   logic [1:0] primo, secondo;
   logic       inizia;
   logic [1:0] partita;
   logic [2:0] vittorie_primo, vittorie_secondo, pareggi;
   logic       occupato, torneo_fine;
   logic [1:0] vincitore;

   int errors = 0;
   int checks = 0;
   int n_inizia = 0;
   int n_gioca = 0;

   morra_torneo dut (
      .clk              (clk),
      .reset            (reset),
      .avvia            (avvia),
      .num_partite      (num_partite),
      .extra_manche     (extra_manche),
      .mossa_primo      (mossa_primo),
      .mossa_secondo    (mossa_secondo),
      .valido_primo     (valido_primo),
      .valido_secondo   (valido_secondo),
      .pronto_primo     (pronto_primo),
      .pronto_secondo   (pronto_secondo),
      .primo            (primo),
      .secondo          (secondo),
      .inizia           (inizia),
      .partita          (partita),
      .vittorie_primo   (vittorie_primo),
      .vittorie_secondo (vittorie_secondo),
      .pareggi          (pareggi),
      .occupato         (occupato),
      .torneo_fine      (torneo_fine),
      .vincitore        (vincitore)
   );

   always #5 clk = ~clk;

   // Pulse counters: inizia cycles, and GIOCA cycles (moves on the bus without inizia).
   always @(negedge clk) begin
      if (inizia) n_inizia++;
      if (!inizia && {primo, secondo} != 4'b0000) n_gioca++;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_pronto;
      for (int k = 0; k < 20 && !(pronto_primo && pronto_secondo); k++) tick;
      checks++;
      if (!(pronto_primo && pronto_secondo)) begin
         errors++;
         $display("FAIL wait_pronto: pronto=%b%b required 11", pronto_primo, pronto_secondo);
      end
   endtask

   task automatic wait_gioca;
      bit found;
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         if (!inizia && {primo, secondo} != 4'b0000) found = 1'b1;
         else tick;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL wait_gioca: no GIOCA cycle seen, required one within 40 cycles");
      end
   endtask

   // Datapath role: result is presented during VERIFICA, the cycle after GIOCA.
   task automatic completa_manche(input logic [1:0] res);
      wait_gioca;
      tick;
      partita = res;
      tick;
      partita = 2'b00;
   endtask

   task automatic gioca_manche(input logic [1:0] m1, input logic [1:0] m2, input logic [1:0] res);
      wait_pronto;
      mossa_primo    = m1;
      mossa_secondo  = m2;
      valido_primo   = 1'b1;
      valido_secondo = 1'b1;
      tick;
      valido_primo   = 1'b0;
      valido_secondo = 1'b0;
      completa_manche(res);
   endtask

   // Start from IDLE/FINE; checks the CONFIG cycle, then moves into ATTESA.
   task automatic avvia_torneo(input logic [2:0] n, input logic [3:0] ex);
      num_partite  = n;
      extra_manche = ex;
      avvia = 1'b1;
      tick;
      avvia = 1'b0;
      checks++;
      if ({inizia, primo, secondo, occupato, torneo_fine} !== {1'b1, ex, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL config: inizia/primo/secondo/occupato/fine=%b required %b",
                  {inizia, primo, secondo, occupato, torneo_fine}, {1'b1, ex, 1'b1, 1'b0});
      end
      checks++;
      if ({vittorie_primo, vittorie_secondo, pareggi} !== 9'd0) begin
         errors++;
         $display("FAIL config_tally: tallies=%0d/%0d/%0d required 0/0/0",
                  vittorie_primo, vittorie_secondo, pareggi);
      end
      tick;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      avvia = 1'b0;
      num_partite = 3'd0;
      extra_manche = 4'd0;
      mossa_primo = 2'b00;
      mossa_secondo = 2'b00;
      valido_primo = 1'b0;
      valido_secondo = 1'b0;
      partita = 2'b00;
      tick;
      tick;
      checks++;
      if ({inizia, primo, secondo, pronto_primo, pronto_secondo, occupato, torneo_fine, vincitore,
           vittorie_primo, vittorie_secondo, pareggi} !== 23'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %h required 0",
                  {inizia, primo, secondo, pronto_primo, pronto_secondo, occupato, torneo_fine,
                   vincitore, vittorie_primo, vittorie_secondo, pareggi});
      end
      reset = 1'b0;
      tick;
      checks++;
      if ({occupato, pronto_primo, pronto_secondo, inizia} !== 4'b0000) begin
         errors++;
         $display("FAIL idle_after_reset: occ/pronto/inizia=%b required 0000",
                  {occupato, pronto_primo, pronto_secondo, inizia});
      end
   endtask

   task automatic test_partita_singola;
      int i0, g0;
      i0 = n_inizia;
      g0 = n_gioca;
      avvia_torneo(3'd1, 4'b0000);
      for (int r = 0; r < 3; r++) gioca_manche(SASSO, FORBICE, 2'b00);
      gioca_manche(SASSO, FORBICE, 2'b01);
      checks++;
      if ({vittorie_primo, torneo_fine, vincitore, occupato} !== {3'd1, 1'b1, 2'b01, 1'b0}) begin
         errors++;
         $display("FAIL single_game: v1/fine/vinc/occ=%b required %b",
                  {vittorie_primo, torneo_fine, vincitore, occupato}, {3'd1, 1'b1, 2'b01, 1'b0});
      end
      checks++;
      if (n_inizia - i0 !== 1) begin
         errors++;
         $display("FAIL single_inizia: pulses=%0d required 1", n_inizia - i0);
      end
      checks++;
      if (n_gioca - g0 !== 4) begin
         errors++;
         $display("FAIL single_rounds: gioca=%0d required 4", n_gioca - g0);
      end
   endtask

   task automatic test_attesa_asimmetrica;
      int g0;
      avvia_torneo(3'd1, 4'b0000);
      g0 = n_gioca;
      mossa_primo  = CARTA;
      valido_primo = 1'b1;
      tick;
      valido_primo = 1'b0;
      checks++;
      if ({pronto_primo, pronto_secondo} !== 2'b01) begin
         errors++;
         $display("FAIL p1_captured: pronto=%b required 01", {pronto_primo, pronto_secondo});
      end
      tick;
      tick;
      checks++;
      if (n_gioca - g0 !== 0 || primo !== 2'b00) begin
         errors++;
         $display("FAIL no_early_gioca: gioca=%0d primo=%b required 0/00", n_gioca - g0, primo);
      end
      mossa_secondo  = SASSO;
      valido_secondo = 1'b1;
      tick;
      valido_secondo = 1'b0;
      checks++;
      if ({primo, secondo, pronto_secondo} !== 5'b00000) begin
         errors++;
         $display("FAIL capture_cycle: primo/secondo/pronto2=%b required 00000",
                  {primo, secondo, pronto_secondo});
      end
      tick;
      checks++;
      if ({primo, secondo} !== {CARTA, SASSO}) begin
         errors++;
         $display("FAIL gioca_moves: primo/secondo=%b required 1001", {primo, secondo});
      end
      tick;
      checks++;
      if ({primo, secondo} !== 4'b0000) begin
         errors++;
         $display("FAIL gioca_one_cycle: primo/secondo=%b required 0000", {primo, secondo});
      end
      partita = 2'b01;
      tick;
      partita = 2'b00;
      checks++;
      if ({vittorie_primo, torneo_fine, vincitore, n_gioca - g0 == 1} !== {3'd1, 1'b1, 2'b01, 1'b1}) begin
         errors++;
         $display("FAIL async_result: v1/fine/vinc/one_gioca=%b required 001 1 01 1",
                  {vittorie_primo, torneo_fine, vincitore, n_gioca - g0 == 1});
      end
   endtask

   task automatic test_mossa_nulla;
      int g0;
      avvia_torneo(3'd1, 4'b0000);
      g0 = n_gioca;
      mossa_primo    = NESSUNA;
      valido_primo   = 1'b1;
      mossa_secondo  = SASSO;
      valido_secondo = 1'b1;
      tick;
      valido_secondo = 1'b0;
      tick;
      tick;
      checks++;
      if ({pronto_primo, pronto_secondo, occupato} !== 3'b101 || n_gioca != g0) begin
         errors++;
         $display("FAIL null_move: pronto/occ=%b gioca=%0d required 101 and 0",
                  {pronto_primo, pronto_secondo, occupato}, n_gioca - g0);
      end
      mossa_primo = FORBICE;
      tick;
      valido_primo = 1'b0;
      completa_manche(2'b10);
      checks++;
      if ({vittorie_secondo, vittorie_primo, vincitore, torneo_fine} !== {3'd1, 3'd0, 2'b10, 1'b1}) begin
         errors++;
         $display("FAIL null_then_valid: v2/v1/vinc/fine=%b required 001000101",
                  {vittorie_secondo, vittorie_primo, vincitore, torneo_fine});
      end
   endtask

   task automatic test_guardia;
      avvia_torneo(3'd1, 4'b0000);
      for (int r = 0; r < 15; r++) gioca_manche(CARTA, CARTA, 2'b00);
      checks++;
      if ({occupato, torneo_fine, pareggi} !== {1'b1, 1'b0, 3'd0}) begin
         errors++;
         $display("FAIL guard_15: occ/fine/pareggi=%b required 10000", {occupato, torneo_fine, pareggi});
      end
      gioca_manche(CARTA, CARTA, 2'b00);
      checks++;
      if ({pareggi, torneo_fine, vincitore} !== {3'd1, 1'b1, 2'b11}) begin
         errors++;
         $display("FAIL guard_16: pareggi/fine/vinc=%b required 001111", {pareggi, torneo_fine, vincitore});
      end
   endtask

   task automatic test_torneo_tre;
      int i0;
      i0 = n_inizia;
      avvia_torneo(3'd3, 4'b1001);
      gioca_manche(SASSO, FORBICE, 2'b01);
      // Mid-tournament avvia and num_partite change must be ignored.
      avvia = 1'b1;
      num_partite = 3'd1;
      tick;
      avvia = 1'b0;
      checks++;
      if ({vittorie_primo, occupato} !== {3'd1, 1'b1}) begin
         errors++;
         $display("FAIL mid_avvia: v1/occ=%b required 0011", {vittorie_primo, occupato});
      end
      gioca_manche(SASSO, CARTA, 2'b10);
      checks++;
      if (torneo_fine !== 1'b0) begin
         errors++;
         $display("FAIL relatch: torneo_fine=%b required 0 after 2 of 3 games", torneo_fine);
      end
      gioca_manche(CARTA, CARTA, 2'b11);
      checks++;
      if ({vittorie_primo, vittorie_secondo, pareggi, vincitore, torneo_fine} !==
          {3'd1, 3'd1, 3'd1, 2'b11, 1'b1}) begin
         errors++;
         $display("FAIL three_games: tallies %0d/%0d/%0d vinc=%b fine=%b required 1/1/1 11 1",
                  vittorie_primo, vittorie_secondo, pareggi, vincitore, torneo_fine);
      end
      checks++;
      if (n_inizia - i0 !== 3) begin
         errors++;
         $display("FAIL three_inizia: pulses=%0d required 3", n_inizia - i0);
      end
   endtask

   task automatic test_limiti_partite;
      avvia_torneo(3'd0, 4'b0000);
      gioca_manche(FORBICE, CARTA, 2'b01);
      checks++;
      if ({torneo_fine, vittorie_primo} !== {1'b1, 3'd1}) begin
         errors++;
         $display("FAIL zero_games: fine/v1=%b required 1001", {torneo_fine, vittorie_primo});
      end
      avvia_torneo(3'd7, 4'b0000);
      for (int g = 0; g < 6; g++) gioca_manche(FORBICE, CARTA, 2'b01);
      checks++;
      if ({torneo_fine, vittorie_primo} !== {1'b0, 3'd6}) begin
         errors++;
         $display("FAIL seven_at6: fine/v1=%b required 0110", {torneo_fine, vittorie_primo});
      end
      gioca_manche(FORBICE, CARTA, 2'b01);
      checks++;
      if ({torneo_fine, vittorie_primo, vincitore} !== {1'b1, 3'd7, 2'b01}) begin
         errors++;
         $display("FAIL seven_games: fine/v1/vinc=%b required 111101", {torneo_fine, vittorie_primo, vincitore});
      end
   endtask

   task automatic test_reset_gioca;
      int g0;
      avvia_torneo(3'd3, 4'b0000);
      gioca_manche(SASSO, FORBICE, 2'b01);
      wait_pronto;
      mossa_primo = SASSO;
      mossa_secondo = CARTA;
      valido_primo = 1'b1;
      valido_secondo = 1'b1;
      tick;
      valido_primo = 1'b0;
      valido_secondo = 1'b0;
      wait_gioca;
      reset = 1'b1;
      tick;
      checks++;
      if ({occupato, primo, secondo, vittorie_primo, pronto_primo, pronto_secondo, inizia} !== 12'd0) begin
         errors++;
         $display("FAIL reset_in_gioca: occ/primo/secondo/v1/pronto/inizia=%b required 0",
                  {occupato, primo, secondo, vittorie_primo, pronto_primo, pronto_secondo, inizia});
      end
      reset = 1'b0;
      tick;
      checks++;
      if (occupato !== 1'b0) begin
         errors++;
         $display("FAIL stay_idle: occupato=%b required 0", occupato);
      end
      avvia_torneo(3'd1, 4'b0000);
      g0 = n_gioca;
      mossa_primo = FORBICE;
      valido_primo = 1'b1;
      tick;
      valido_primo = 1'b0;
      tick;
      tick;
      checks++;
      if (n_gioca != g0 || pronto_secondo !== 1'b1) begin
         errors++;
         $display("FAIL held_cleared: gioca=%0d pronto2=%b required 0 and 1", n_gioca - g0, pronto_secondo);
      end
      mossa_secondo = SASSO;
      valido_secondo = 1'b1;
      tick;
      valido_secondo = 1'b0;
      completa_manche(2'b10);
      checks++;
      if ({vittorie_secondo, vincitore, torneo_fine} !== {3'd1, 2'b10, 1'b1}) begin
         errors++;
         $display("FAIL after_reset_game: v2/vinc/fine=%b required 001101", {vittorie_secondo, vincitore, torneo_fine});
      end
   endtask

   initial begin
      test_reset;
      test_partita_singola;
      test_attesa_asimmetrica;
      test_mossa_nulla;
      test_guardia;
      test_torneo_tre;
      test_limiti_partite;
      test_reset_gioca;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
